// File: rtl/cnn_params_pkg.sv
// rtl/cnn_params_pkg.sv - shared CNN dimensions, bit widths and FC-stage state encodings
package cnn_params_pkg;

    // Layer-2 max-pooling output geometry; the FC stage flattens this volume.
    localparam int L2_POOL_CH = 8;
    localparam int L2_POOL_H  = 6;
    localparam int L2_POOL_W  = 6;

    localparam int FC_NUM_INPUTS  = L2_POOL_CH * L2_POOL_H * L2_POOL_W;
    localparam int FC_NUM_CLASSES = 10;

    localparam int CNN_FEATURE_BW = 8;   // unsigned activations
    localparam int CNN_WEIGHT_BW  = 8;   // signed weights
    localparam int CNN_BIAS_BW    = 16;  // signed biases
    localparam int CNN_ACC_BW     = 25;  // signed accumulators / scores
    localparam int CNN_WADDR_BW   = 12;  // weight ROM address

    typedef enum logic [2:0] {
        FC_IDLE   = 3'd0,
        FC_MAC    = 3'd1,
        FC_DRAIN  = 3'd2,
        FC_ARGMAX = 3'd3,
        FC_DONE   = 3'd4
    } fc_state_t;

endpackage

// File: rtl/fc_mac_unit.sv
// rtl/fc_mac_unit.sv - single-stage multiply-accumulate for the FC classifier
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       synchronous clear of the accumulator
//   en          accumulate this cycle (feature/weight/bias aligned)
//   load_bias   start a new class: seed with bias instead of running sum
//   feature     unsigned activation
//   weight      signed weight
//   bias        signed bias for the current class
//   acc         registered accumulator
module fc_mac_unit
    import cnn_params_pkg::*;
#(
    parameter int FEATURE_BITWIDTH = CNN_FEATURE_BW,
    parameter int WEIGHT_BITWIDTH  = CNN_WEIGHT_BW,
    parameter int BIAS_BITWIDTH    = CNN_BIAS_BW,
    parameter int ACC_BITWIDTH     = CNN_ACC_BW
)(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           en,
    input  logic                           load_bias,
    input  logic [FEATURE_BITWIDTH-1:0]    feature,
    input  logic [WEIGHT_BITWIDTH-1:0]     weight,
    input  logic [BIAS_BITWIDTH-1:0]       bias,
    output logic signed [ACC_BITWIDTH-1:0] acc
);

    // Unsigned feature gets a zero guard bit so the product is a plain signed multiply.
    localparam int PROD_BW = FEATURE_BITWIDTH + 1 + WEIGHT_BITWIDTH - 1 + 1;

    logic signed [PROD_BW-1:0]      f_ext;
    logic signed [PROD_BW-1:0]      w_ext;
    logic signed [PROD_BW-1:0]      product;
    logic signed [ACC_BITWIDTH-1:0] prod_ext;
    logic signed [ACC_BITWIDTH-1:0] base;
    logic signed [ACC_BITWIDTH-1:0] acc_sum;

    always_comb begin
        f_ext    = {{(PROD_BW-FEATURE_BITWIDTH){1'b0}}, feature};
        w_ext    = {{(PROD_BW-WEIGHT_BITWIDTH){weight[WEIGHT_BITWIDTH-1]}}, weight};
        // Magnitude never exceeds 2^(PROD_BW-1), so the truncated product is exact.
        product  = f_ext * w_ext;
        prod_ext = {{(ACC_BITWIDTH-PROD_BW){product[PROD_BW-1]}}, product};
        base     = load_bias ? {{(ACC_BITWIDTH-BIAS_BITWIDTH){bias[BIAS_BITWIDTH-1]}}, bias}
                             : acc;
        acc_sum  = base + prod_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_sum;
        end
    end

endmodule

// File: rtl/fc_layer_classifier.sv
// rtl/fc_layer_classifier.sv - fully-connected 288->10 classifier with ROM weights and argmax
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   soft_rst         synchronous clear, same effect as rst_n
//   data_valid       start request, sampled only in IDLE
//   feature_map_in   flattened pooled map, element n at [n*8 +: 8]
//   bias_in          class biases, class k at [k*16 +: 16]
//   weight_rd_en     ROM read strobe
//   weight_addr      ROM address k*NUM_INPUTS + n
//   weight_data      ROM data, one cycle after the strobe
//   busy             high outside IDLE
//   result_valid     one-cycle completion pulse
//   class_scores     final scores, class k at [k*25 +: 25]
//   predicted_class  argmax index (lowest index on ties)
module fc_layer_classifier
    import cnn_params_pkg::*;
#(
    parameter int NUM_INPUTS       = FC_NUM_INPUTS,
    parameter int NUM_CLASSES      = FC_NUM_CLASSES,
    parameter int FEATURE_BITWIDTH = CNN_FEATURE_BW,
    parameter int WEIGHT_BITWIDTH  = CNN_WEIGHT_BW,
    parameter int BIAS_BITWIDTH    = CNN_BIAS_BW,
    parameter int ACC_BITWIDTH     = CNN_ACC_BW,
    parameter int ADDR_BITWIDTH    = CNN_WADDR_BW
)(
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    soft_rst,
    input  logic                                    data_valid,
    input  logic [NUM_INPUTS*FEATURE_BITWIDTH-1:0]  feature_map_in,
    input  logic [NUM_CLASSES*BIAS_BITWIDTH-1:0]    bias_in,
    output logic                                    weight_rd_en,
    output logic [ADDR_BITWIDTH-1:0]                weight_addr,
    input  logic [WEIGHT_BITWIDTH-1:0]              weight_data,
    output logic                                    busy,
    output logic                                    result_valid,
    output logic [NUM_CLASSES*ACC_BITWIDTH-1:0]     class_scores,
    output logic [$clog2(NUM_CLASSES)-1:0]          predicted_class
);

    localparam int N_W = $clog2(NUM_INPUTS);
    localparam int K_W = $clog2(NUM_CLASSES);

    fc_state_t state_q, state_d;

    logic [FEATURE_BITWIDTH-1:0] feat_mem [NUM_INPUTS];

    // Issue-side counters (track weight_addr) and their ROM-latency-aligned copies.
    logic [ADDR_BITWIDTH-1:0] addr_q;
    logic [N_W-1:0]           n_q, n_d1;
    logic [K_W-1:0]           k_q, k_d1, k_d2;
    logic                     val_d1, wr_d2;
    logic                     n_last, mac_last;

    logic signed [ACC_BITWIDTH-1:0] mac_acc;
    logic signed [ACC_BITWIDTH-1:0] score_buf [NUM_CLASSES];
    logic [NUM_CLASSES*ACC_BITWIDTH-1:0] score_flat;

    logic [K_W-1:0]                 am_k, best_idx, cand_idx;
    logic signed [ACC_BITWIDTH-1:0] best_val, cand_val;
    logic                           am_last, take;

    assign n_last   = (n_q == N_W'(NUM_INPUTS - 1));
    assign mac_last = n_last && (k_q == K_W'(NUM_CLASSES - 1));
    assign am_last  = (am_k == K_W'(NUM_CLASSES - 1));
    assign weight_addr = addr_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FC_IDLE;
        end else if (soft_rst) begin
            state_q <= FC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        busy         = 1'b1;
        weight_rd_en = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            FC_IDLE: begin
                busy = 1'b0;
                if (data_valid) state_d = FC_MAC;
            end
            FC_MAC: begin
                weight_rd_en = 1'b1;
                if (mac_last) state_d = FC_DRAIN;
            end
            FC_DRAIN: begin
                state_d = FC_ARGMAX;
            end
            FC_ARGMAX: begin
                if (am_last) state_d = FC_DONE;
            end
            FC_DONE: begin
                result_valid = 1'b1;
                state_d      = FC_IDLE;
            end
            default: begin
                state_d = FC_IDLE;
            end
        endcase
    end

    // ---------------- feature latch ----------------
    always_ff @(posedge clk) begin
        if (state_q == FC_IDLE && data_valid && !soft_rst) begin
            for (int n = 0; n < NUM_INPUTS; n++) begin
                feat_mem[n] <= feature_map_in[n*FEATURE_BITWIDTH +: FEATURE_BITWIDTH];
            end
        end
    end

    // ---------------- address / index counters ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {addr_q, n_q, k_q, n_d1, k_d1, k_d2, val_d1, wr_d2} <= '0;
        end else if (soft_rst) begin
            {addr_q, n_q, k_q, n_d1, k_d1, k_d2, val_d1, wr_d2} <= '0;
        end else begin
            val_d1 <= (state_q == FC_MAC);
            n_d1   <= n_q;
            k_d1   <= k_q;
            // The MAC register holds a finished class one cycle after its last term.
            wr_d2  <= val_d1 && (n_d1 == N_W'(NUM_INPUTS - 1));
            k_d2   <= k_d1;
            if (state_q == FC_IDLE && data_valid) begin
                {addr_q, n_q, k_q} <= '0;
            end else if (state_q == FC_MAC && !mac_last) begin
                // On the final address everything holds, so weight_addr keeps its value.
                addr_q <= addr_q + ADDR_BITWIDTH'(1);
                if (n_last) begin
                    n_q <= '0;
                    k_q <= k_q + K_W'(1);
                end else begin
                    n_q <= n_q + N_W'(1);
                end
            end
        end
    end

    fc_mac_unit #(
        .FEATURE_BITWIDTH (FEATURE_BITWIDTH),
        .WEIGHT_BITWIDTH  (WEIGHT_BITWIDTH),
        .BIAS_BITWIDTH    (BIAS_BITWIDTH),
        .ACC_BITWIDTH     (ACC_BITWIDTH)
    ) u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (soft_rst),
        .en        (val_d1),
        .load_bias (n_d1 == '0),
        .feature   (feat_mem[n_d1]),
        .weight    (weight_data),
        .bias      (bias_in[k_d1*BIAS_BITWIDTH +: BIAS_BITWIDTH]),
        .acc       (mac_acc)
    );

    // ---------------- argmax ----------------
    always_comb begin
        take     = (am_k == '0) || (score_buf[am_k] > best_val);
        cand_val = take ? score_buf[am_k] : best_val;
        cand_idx = take ? am_k : best_idx;
    end

    always_comb begin
        score_flat = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            score_flat[k*ACC_BITWIDTH +: ACC_BITWIDTH] = score_buf[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CLASSES; k++) score_buf[k] <= '0;
            {am_k, best_idx, best_val, class_scores, predicted_class} <= '0;
        end else if (soft_rst) begin
            for (int k = 0; k < NUM_CLASSES; k++) score_buf[k] <= '0;
            {am_k, best_idx, best_val, class_scores, predicted_class} <= '0;
        end else begin
            // Class 9 lands during the first ARGMAX cycle, well before the scan reaches it.
            if (wr_d2) score_buf[k_d2] <= mac_acc;
            case (state_q)
                FC_DRAIN: am_k <= '0;
                FC_ARGMAX: begin
                    am_k     <= am_k + K_W'(1);
                    best_val <= cand_val;
                    best_idx <= cand_idx;
                    if (am_last) begin
                        class_scores    <= score_flat;
                        predicted_class <= cand_idx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_classifier.sv
// tb/tb_fc_layer_classifier.sv - directed self-checking bench for fc_layer_classifier
module tb_fc_layer_classifier;

    localparam int NI  = 288;
    localparam int NC  = 10;
    localparam int LAT = NC * NI + NC + 1;

    logic           clk;
    logic           rst_n;
    logic           soft_rst;
    logic           data_valid;
    logic [NI*8-1:0]  feature_map_in;
    logic [NC*16-1:0] bias_in;
    logic           weight_rd_en;
    logic [11:0]    weight_addr;
    logic [7:0]     weight_data;
    logic           busy;
    logic           result_valid;
    logic [NC*25-1:0] class_scores;
    logic [3:0]     predicted_class;

    fc_layer_classifier dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .soft_rst        (soft_rst),
        .data_valid      (data_valid),
        .feature_map_in  (feature_map_in),
        .bias_in         (bias_in),
        .weight_rd_en    (weight_rd_en),
        .weight_addr     (weight_addr),
        .weight_data     (weight_data),
        .busy            (busy),
        .result_valid    (result_valid),
        .class_scores    (class_scores),
        .predicted_class (predicted_class)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: mode 0 returns a constant, mode 1 returns the low address byte.
    int        rom_mode;
    logic [7:0] w_const;
    always @(posedge clk) begin
        if (weight_rd_en) weight_data <= (rom_mode == 0) ? w_const : weight_addr[7:0];
        else              weight_data <= 8'h5A;
    end

    // Address-sequence and completion-pulse monitor.
    int   run_len  = 0;
    int   addr_err = 0;
    int   rv_count = 0;
    logic rd_prev  = 1'b0;
    always @(negedge clk) begin
        if (weight_rd_en) begin
            if (!rd_prev) run_len = 0;
            if (weight_addr !== 12'(run_len)) addr_err++;
            run_len++;
        end
        rd_prev = weight_rd_en;
        if (result_valid) rv_count++;
    end

    int     n_checks = 0;
    int     n_fail   = 0;
    int     e0;
    longint exp_scores [NC];
    int     exp_pred;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic longint score_of(input int k);
        return longint'($signed(class_scores[k*25 +: 25]));
    endfunction

    task automatic set_features(input logic [7:0] v);
        for (int n = 0; n < NI; n++) feature_map_in[n*8 +: 8] = v;
    endtask

    task automatic calc_pred();
        exp_pred = 0;
        for (int k = 1; k < NC; k++) if (exp_scores[k] > exp_scores[exp_pred]) exp_pred = k;
    endtask

    task automatic wait_edge(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_run(input string tag);
        @(posedge clk);
        #1 data_valid = 1'b1;
        @(posedge clk);
        #1 data_valid = 1'b0;
        e0 = cyc;
        @(negedge clk);
        chk({tag, " busy_rise"}, busy, 1);
        chk({tag, " rd_en_first"}, weight_rd_en, 1);
        chk({tag, " addr_first"}, weight_addr, 0);
    endtask

    task automatic wait_result(input string tag);
        int lat;
        lat = -1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (result_valid) begin
                lat = cyc - e0;
                break;
            end
        end
        chk({tag, " latency"}, lat, LAT);
        for (int k = 0; k < NC; k++) chk($sformatf("%s score%0d", tag, k), score_of(k), exp_scores[k]);
        chk({tag, " pred"}, predicted_class, exp_pred);
        chk({tag, " run_len"}, run_len, NC * NI);
        chk({tag, " addr_seq"}, addr_err, 0);
        @(negedge clk);
        chk({tag, " rv_pulse"}, result_valid, 0);
        chk({tag, " busy_fall"}, busy, 0);
    endtask

    initial begin
        int rv_before;
        logic signed [7:0] wb;

        rst_n = 1'b0; soft_rst = 1'b0; data_valid = 1'b0;
        feature_map_in = '0; bias_in = '0; rom_mode = 0; w_const = 8'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst result_valid", result_valid, 0);
        chk("rst rd_en", weight_rd_en, 0);
        chk("rst addr", weight_addr, 0);
        chk("rst pred", predicted_class, 0);
        chk("rst scores", class_scores, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Zero weights, bias_k = k*100
        set_features(8'h37);
        for (int k = 0; k < NC; k++) begin
            bias_in[k*16 +: 16] = 16'(k * 100);
            exp_scores[k] = k * 100;
        end
        rom_mode = 0; w_const = 8'd0;
        calc_pred();
        start_run("zero_w");
        wait_result("zero_w");

        // Max positive: every class ties, lowest index wins
        set_features(8'd255);
        bias_in = '0;
        w_const = 8'd127;
        for (int k = 0; k < NC; k++) exp_scores[k] = 255 * 127 * NI;
        calc_pred();
        start_run("max_pos");
        wait_result("max_pos");

        // Max negative, class 3 one higher
        w_const = 8'h80;
        bias_in[3*16 +: 16] = 16'd1;
        for (int k = 0; k < NC; k++) exp_scores[k] = -255 * 128 * NI + ((k == 3) ? 1 : 0);
        calc_pred();
        start_run("max_neg");
        wait_result("max_neg");

        // data_valid while busy is ignored, including new feature data
        set_features(8'd2);
        bias_in = '0;
        w_const = 8'd3;
        for (int k = 0; k < NC; k++) exp_scores[k] = 2 * 3 * NI;
        calc_pred();
        rv_before = rv_count;
        start_run("busy_dv");
        set_features(8'd255);
        wait_edge(e0 + 4);
        data_valid = 1'b1;
        @(posedge clk);
        #1 data_valid = 1'b0;
        wait_edge(e0 + 1999);
        data_valid = 1'b1;
        @(posedge clk);
        #1 data_valid = 1'b0;
        wait_result("busy_dv");
        chk("busy_dv rv_count", rv_count - rv_before, 1);

        // soft_rst mid-inference
        start_run("soft_rst");
        wait_edge(e0 + 999);
        soft_rst = 1'b1;
        @(posedge clk);
        #1 soft_rst = 1'b0;
        @(negedge clk);
        chk("soft_rst busy", busy, 0);
        chk("soft_rst rd_en", weight_rd_en, 0);
        chk("soft_rst result_valid", result_valid, 0);
        chk("soft_rst addr", weight_addr, 0);
        chk("soft_rst pred", predicted_class, 0);
        chk("soft_rst scores", class_scores, 0);

        // One-hot at n=37, ROM = address byte: checks flatten order and ROM alignment
        feature_map_in = '0;
        feature_map_in[37*8 +: 8] = 8'd1;
        bias_in = '0;
        rom_mode = 1;
        for (int k = 0; k < NC; k++) begin
            wb = 8'((k * NI + 37) % 256);
            exp_scores[k] = longint'(wb);
        end
        calc_pred();
        start_run("one_hot");
        wait_result("one_hot");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
